// File: rtl/ho_pkg.sv
// ho_pkg: shared types, defaults and helpers for the handover downlink server.
//   ho_state_t : router FSM states (IDLE, SERVE, DRAIN, SWITCH)
//   idx_w()    : width of an index able to address n items (minimum 1)
package ho_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } ho_state_t;

    localparam int N_BS_DEF       = 3;
    localparam int DATA_W_DEF     = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ho_fifo.sv
// ho_fifo: synchronous FIFO with asynchronous active-high reset.
//   clk, reset : clock, async reset (clears pointers, count and storage)
//   push, pop  : write/read strobes (ignored when full/empty respectively)
//   wr_data    : word to write
//   rd_data    : word at the head (valid when !empty)
//   full, empty: occupancy flags
//   count      : number of words stored (0..DEPTH)
module ho_fifo #(
    parameter  int DATA_W = 4,
    parameter  int DEPTH  = 4,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is reset too so the head never presents X downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ho_server_router.sv
// ho_server_router: buffers server words and forwards them to the current
// serving base station; on a handover it drains to the old BS, then switches.
//   clk, reset     : clock, async active-high reset
//   sv_data/valid  : server word in; sv_ready back-pressures the server
//   tgt_req_valid  : per-BS handover request strobes
//   tgt_req_id     : per-BS requested target (slice i from BS i)
//   bs_data/valid  : per-BS downlink (only slice cur_target is ever active)
//   bs_ready       : per-BS accept
//   cur_target     : serving BS index
//   ho_busy        : handover in progress (DRAIN or SWITCH)
//   ho_done        : one-cycle pulse announcing a target update
//   req_err        : one-cycle pulse, out-of-range request dropped
//   fifo_count     : words buffered
module ho_server_router
    import ho_pkg::*;
#(
    parameter  int N_BS       = N_BS_DEF,
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ID_W       = idx_w(N_BS),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      sv_data,
    input  logic                   sv_valid,
    output logic                   sv_ready,
    input  logic [N_BS-1:0]        tgt_req_valid,
    input  logic [N_BS*ID_W-1:0]   tgt_req_id,
    output logic [N_BS*DATA_W-1:0] bs_data,
    output logic [N_BS-1:0]        bs_valid,
    input  logic [N_BS-1:0]        bs_ready,
    output logic [ID_W-1:0]        cur_target,
    output logic                   ho_busy,
    output logic                   ho_done,
    output logic                   req_err,
    output logic [CNT_W-1:0]       fifo_count
);

    ho_state_t         state;
    ho_state_t         state_next;
    logic [ID_W-1:0]   cur_target_q;
    logic [ID_W-1:0]   pending_q;
    logic [ID_W-1:0]   target_d;
    logic              load_target;
    logic              load_pending;
    logic              set_done;
    logic              set_err;
    logic              ho_done_q;
    logic              req_err_q;

    logic              req_any;
    logic [ID_W-1:0]   req_id;
    logic              req_ok;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              out_active;
    logic              sel_ready;

    ho_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (sv_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Fixed-priority arbiter: lowest asserted BS index wins.
    always_comb begin
        req_any = 1'b0;
        req_id  = '0;
        for (int unsigned i = 0; i < N_BS; i++) begin
            if (tgt_req_valid[i] && !req_any) begin
                req_any = 1'b1;
                req_id  = tgt_req_id[i*ID_W +: ID_W];
            end
        end
    end

    assign req_ok = ({{(32-ID_W){1'b0}}, req_id} < 32'(N_BS));

    // State and handover registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cur_target_q <= '0;
            pending_q    <= '0;
            ho_done_q    <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state     <= state_next;
            ho_done_q <= set_done;
            req_err_q <= set_err;
            if (load_target) begin
                cur_target_q <= target_d;
            end
            if (load_pending) begin
                pending_q <= req_id;
            end
        end
    end

    // Next-state logic. For a handover, ho_done is raised on entry to
    // SWITCH so the pulse coincides with the SWITCH cycle that commits
    // the new target.
    always_comb begin
        state_next   = state;
        target_d     = req_id;
        load_target  = 1'b0;
        load_pending = 1'b0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (req_ok) begin
                        load_target = 1'b1;
                        set_done    = 1'b1;
                        state_next  = SERVE;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (req_any) begin
                    if (!req_ok) begin
                        set_err = 1'b1;
                    end else if (req_id != cur_target_q) begin
                        load_pending = 1'b1;
                        state_next   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    set_done   = 1'b1;
                    state_next = SWITCH;
                end
            end
            SWITCH: begin
                target_d    = pending_q;
                load_target = 1'b1;
                state_next  = SERVE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: only the serving slice is ever driven.
    always_comb begin
        sv_ready   = !fifo_full && (state == IDLE || state == SERVE);
        out_active = !fifo_empty && (state == SERVE || state == DRAIN);
        ho_busy    = (state == DRAIN || state == SWITCH);
        bs_valid   = '0;
        bs_data    = '0;
        sel_ready  = 1'b0;
        for (int unsigned i = 0; i < N_BS; i++) begin
            if (ID_W'(i) == cur_target_q) begin
                bs_valid[i]                  = out_active;
                bs_data[i*DATA_W +: DATA_W]  = fifo_head;
                sel_ready                    = bs_ready[i];
            end
        end
    end

    assign fifo_push  = sv_valid && sv_ready;
    assign fifo_pop   = out_active && sel_ready;
    assign cur_target = cur_target_q;
    assign ho_done    = ho_done_q;
    assign req_err    = req_err_q;

endmodule

// File: tb/tb_ho_server_router.sv
module tb_ho_server_router;

    localparam int N_BS   = 3;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_SERVE  = 1;
    localparam int PH_DRAIN  = 2;
    localparam int PH_SWITCH = 3;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [DATA_W-1:0]      sv_data = '0;
    logic                   sv_valid = 1'b0;
    logic                   sv_ready;
    logic [N_BS-1:0]        tgt_req_valid = '0;
    logic [N_BS*ID_W-1:0]   tgt_req_id = '0;
    logic [N_BS*DATA_W-1:0] bs_data;
    logic [N_BS-1:0]        bs_valid;
    logic [N_BS-1:0]        bs_ready = '0;
    logic [ID_W-1:0]        cur_target;
    logic                   ho_busy;
    logic                   ho_done;
    logic                   req_err;
    logic [CNT_W-1:0]       fifo_count;

    ho_server_router #(
        .N_BS       (N_BS),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sv_data       (sv_data),
        .sv_valid      (sv_valid),
        .sv_ready      (sv_ready),
        .tgt_req_valid (tgt_req_valid),
        .tgt_req_id    (tgt_req_id),
        .bs_data       (bs_data),
        .bs_valid      (bs_valid),
        .bs_ready      (bs_ready),
        .cur_target    (cur_target),
        .ho_busy       (ho_busy),
        .ho_done       (ho_done),
        .req_err       (req_err),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: scoreboard queue holds every accepted word in order;
    // its size is the expected buffer occupancy.
    logic [DATA_W-1:0] sb_q[$];
    int m_phase = PH_IDLE;
    int m_tgt   = 0;
    int m_pend  = 0;
    int m_done  = 0;
    int m_err   = 0;
    int tgt_now = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [N_BS*ID_W-1:0] ids(input int a, input int b, input int c);
        logic [N_BS*ID_W-1:0] r;
        r = '0;
        r[ID_W-1:0]        = ID_W'(a);
        r[2*ID_W-1:ID_W]   = ID_W'(b);
        r[3*ID_W-1:2*ID_W] = ID_W'(c);
        return r;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_phase = PH_IDLE;
        m_tgt   = 0;
        m_pend  = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #3;
        sv_valid = 1'b0; tgt_req_valid = '0; bs_ready = '0;
        reset = 1'b1;
        #1;
        chk("rst_bs_valid", 32'(bs_valid), 0);
        chk("rst_bs_data", 32'(bs_data), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_target", 32'(cur_target), 0);
        chk("rst_busy", 32'(ho_busy), 0);
        chk("rst_done", 32'(ho_done), 0);
        chk("rst_err", 32'(req_err), 0);
        model_reset();
        @(negedge clk);
        #3;
        reset = 1'b0;
    endtask

    // One cycle of stimulus, output checks against the model, then model update.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [N_BS-1:0] rv,
                         input logic [N_BS*ID_W-1:0] rid, input logic [N_BS-1:0] rdy);
        int cnt;
        int win;
        int nd;
        int ne;
        logic exp_rdy;
        logic [N_BS-1:0] exp_v;
        @(negedge clk);
        sv_valid = v; sv_data = d; tgt_req_valid = rv; tgt_req_id = rid; bs_ready = rdy;
        #1;
        cnt     = sb_q.size();
        tgt_now = m_tgt;
        exp_rdy = (cnt < DEPTH) && (m_phase == PH_IDLE || m_phase == PH_SERVE);
        exp_v   = '0;
        if (cnt > 0 && (m_phase == PH_SERVE || m_phase == PH_DRAIN)) exp_v[m_tgt] = 1'b1;
        chk("sv_ready", 32'(sv_ready), 32'(exp_rdy));
        chk("bs_valid", 32'(bs_valid), 32'(exp_v));
        chk("cur_target", 32'(cur_target), 32'(m_tgt));
        chk("fifo_count", 32'(fifo_count), 32'(cnt));
        chk("ho_busy", 32'(ho_busy), 32'(m_phase == PH_DRAIN || m_phase == PH_SWITCH));
        chk("ho_done", 32'(ho_done), 32'(m_done));
        chk("req_err", 32'(req_err), 32'(m_err));
        for (int i = 0; i < N_BS; i++) begin
            if (i != m_tgt) chk("other_data", 32'(bs_data[i*DATA_W +: DATA_W]), 0);
            else if (exp_v[i]) chk("head_data", 32'(bs_data[i*DATA_W +: DATA_W]), 32'(sb_q[0]));
        end
        if (v && exp_rdy) sb_q.push_back(d);
        win = -1;
        for (int i = 0; i < N_BS; i++) begin
            if (rv[i] && win < 0) win = int'(rid[i*ID_W +: ID_W]);
        end
        nd = 0;
        ne = 0;
        case (m_phase)
            PH_IDLE: begin
                if (win >= N_BS) ne = 1;
                else if (win >= 0) begin m_tgt = win; nd = 1; m_phase = PH_SERVE; end
            end
            PH_SERVE: begin
                if (win >= N_BS) ne = 1;
                else if (win >= 0 && win != m_tgt) begin m_pend = win; m_phase = PH_DRAIN; end
            end
            PH_DRAIN: begin
                if (cnt == 0) begin nd = 1; m_phase = PH_SWITCH; end
            end
            default: begin
                m_tgt = m_pend; m_phase = PH_SERVE;
            end
        endcase
        m_done = nd;
        m_err  = ne;
    endtask

    // Monitor: whenever a BS accepts a word, it must be the oldest
    // outstanding word and go to the serving BS.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            for (int i = 0; i < N_BS; i++) begin
                if (bs_valid[i] && bs_ready[i]) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL spurious_out: bs %0d delivered %0h with nothing expected", i,
                                 bs_data[i*DATA_W +: DATA_W]);
                    end else begin
                        chk("out_data", 32'(bs_data[i*DATA_W +: DATA_W]), 32'(sb_q.pop_front()));
                        chk("out_dest", 32'(i), 32'(tgt_now));
                    end
                end
            end
        end
    end

    localparam logic [N_BS-1:0] ALL = '1;

    initial begin
        do_reset();

        // Reset mid-DRAIN with 3 words buffered.
        cycle(1'b0, '0, 3'b001, ids(1, 0, 0), ALL);
        repeat (3) cycle(1'b1, DATA_W'($urandom), '0, '0, 3'b000);
        cycle(1'b0, '0, 3'b100, ids(0, 0, 2), 3'b000);
        repeat (2) cycle(1'b0, '0, '0, '0, 3'b000);
        do_reset();

        // A,B,C buffered in IDLE, then BS1 requests target 2.
        cycle(1'b1, 4'hA, '0, '0, ALL);
        cycle(1'b1, 4'hB, '0, '0, ALL);
        cycle(1'b1, 4'hC, '0, '0, ALL);
        cycle(1'b0, '0, 3'b010, ids(0, 2, 0), ALL);
        repeat (5) cycle(1'b0, '0, '0, '0, ALL);

        // Empty-FIFO handover to BS0; a request during DRAIN is ignored.
        cycle(1'b0, '0, 3'b001, ids(0, 0, 0), ALL);
        cycle(1'b0, '0, 3'b010, ids(0, 1, 0), ALL);
        repeat (3) cycle(1'b0, '0, '0, '0, ALL);

        // Serving BS0 with words buffered; BS2 requests target 1.
        cycle(1'b1, 4'h5, '0, '0, 3'b110);
        cycle(1'b1, 4'h6, '0, '0, 3'b110);
        cycle(1'b1, 4'h7, 3'b100, ids(0, 0, 1), ALL);
        repeat (6) cycle(1'b1, DATA_W'($urandom), '0, '0, ALL);

        // Simultaneous requests: lowest BS wins; then an out-of-range id.
        cycle(1'b0, '0, 3'b101, ids(2, 0, 1), ALL);
        repeat (4) cycle(1'b0, '0, '0, '0, ALL);
        cycle(1'b0, '0, 3'b001, ids(3, 0, 0), ALL);
        repeat (2) cycle(1'b0, '0, '0, '0, ALL);

        // Fill to full under back-pressure, then release with pushes.
        repeat (6) cycle(1'b1, DATA_W'($urandom), '0, '0, 3'b000);
        repeat (6) cycle(1'b1, DATA_W'($urandom), '0, '0, ALL);

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            logic [N_BS-1:0] rv;
            logic [N_BS*ID_W-1:0] rid;
            if (k % 800 == 799) do_reset();
            rv = '0;
            for (int i = 0; i < N_BS; i++) rv[i] = ($urandom_range(0, 9) == 0);
            rid = ids(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            cycle(($urandom_range(0, 1) == 1), DATA_W'($urandom), rv, rid,
                  N_BS'($urandom) | N_BS'($urandom));
        end
        repeat (12) cycle(1'b0, '0, '0, '0, ALL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
